// File: rtl/color_centroid.sv
`timescale 1ns/1ps
// color_centroid: classifies an RGB565 pixel stream against a colour window,
// accumulates per-frame coordinate sums of the hits and divides them at each
// frame boundary to publish the object centroid.
// Optional macro COLOR_CENTROID_BBOX_EN adds a per-frame bounding box of hits.
module color_centroid #(
  parameter int unsigned H_PIXEL = 640,
  parameter int unsigned V_PIXEL = 480,
  parameter logic [4:0]  R_MIN   = 5'd20,
  parameter logic [5:0]  G_MAX   = 6'd24,
  parameter logic [4:0]  B_MAX   = 5'd12,
  parameter logic [19:0] MIN_PIX = 20'd64
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pix_vsync,
  input  logic        pix_href,
  input  logic        pix_wr_en,
  input  logic [15:0] pix_data,
  output logic        obj_valid,
  output logic        obj_found,
  output logic [11:0] obj_x,
  output logic [11:0] obj_y,
  output logic [19:0] obj_pix_cnt,
`ifdef COLOR_CENTROID_BBOX_EN
  output logic [11:0] obj_x_min,
  output logic [11:0] obj_x_max,
  output logic [11:0] obj_y_min,
  output logic [11:0] obj_y_max,
`endif
  output logic        busy
);

  localparam logic [11:0] X_LIM = 12'(H_PIXEL);
  localparam logic [11:0] Y_LIM = 12'(V_PIXEL);

  typedef enum logic [2:0] {IDLE, CHECK, DIV_X, DIV_Y, DONE} state_t;

  state_t      state, state_next;

  logic        vsync_r, vsync_rr, href_r, href_rr, wr_en_r;
  logic [15:0] data_r;
  logic        frame_start, line_start, line_end, start;

  logic [11:0] x_cnt, y_cnt, x_cur;
  logic        line_has_pix, in_range, color_hit, hit;
  logic        frame_seen;

  logic [31:0] sum_x, sum_y;
  logic [19:0] cnt;
  logic [31:0] snap_sum_x, snap_sum_y;
  logic [19:0] snap_cnt;

  logic [31:0] div_rem, div_quo;
  logic [32:0] div_shift;
  logic [31:0] div_sub;
  logic        div_ge;
  logic [4:0]  iter;
  logic [11:0] quo_x;
  logic        found;
  logic        publish;

`ifdef COLOR_CENTROID_BBOX_EN
  logic [11:0] x_min, x_max, y_min, y_max;
  logic [11:0] snap_x_min, snap_x_max, snap_y_min, snap_y_max;
`endif

  // Register the raw camera inputs and keep a delayed copy for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_r  <= 1'b0;
      vsync_rr <= 1'b0;
      href_r   <= 1'b0;
      href_rr  <= 1'b0;
      wr_en_r  <= 1'b0;
      data_r   <= '0;
    end else begin
      vsync_r  <= pix_vsync;
      vsync_rr <= vsync_r;
      href_r   <= pix_href;
      href_rr  <= href_r;
      wr_en_r  <= pix_wr_en;
      data_r   <= pix_data;
    end
  end

  // Edge strobes, current pixel coordinate and colour-window classification
  always_comb begin
    frame_start = vsync_r & ~vsync_rr;
    line_start  = href_r & ~href_rr;
    line_end    = ~href_r & href_rr;
    start       = frame_start & frame_seen;
    x_cur       = line_start ? 12'd0 : x_cnt;
    in_range    = (x_cur < X_LIM) && (y_cnt < Y_LIM);
    color_hit   = (data_r[15:11] >= R_MIN) && (data_r[10:5] <= G_MAX) &&
                  (data_r[4:0] <= B_MAX);
    hit         = wr_en_r && in_range && color_hit;
  end

  // Track pixel x/y; only lines that actually carried pixels advance y
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_cnt        <= '0;
      y_cnt        <= '0;
      line_has_pix <= 1'b0;
    end else begin
      if (wr_en_r && (x_cur < X_LIM))
        x_cnt <= x_cur + 12'd1;
      else
        x_cnt <= x_cur;

      if (line_start)
        line_has_pix <= wr_en_r;
      else if (wr_en_r)
        line_has_pix <= 1'b1;

      if (frame_start)
        y_cnt <= '0;
      else if (line_end && (line_has_pix || wr_en_r) && (y_cnt < Y_LIM))
        y_cnt <= y_cnt + 12'd1;
    end
  end

  // Per-frame hit accumulation, cleared at every frame boundary
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sum_x      <= '0;
      sum_y      <= '0;
      cnt        <= '0;
      frame_seen <= 1'b0;
`ifdef COLOR_CENTROID_BBOX_EN
      x_min      <= 12'hFFF;
      x_max      <= '0;
      y_min      <= 12'hFFF;
      y_max      <= '0;
`endif
    end else if (frame_start) begin
      sum_x      <= '0;
      sum_y      <= '0;
      cnt        <= '0;
      frame_seen <= 1'b1;
`ifdef COLOR_CENTROID_BBOX_EN
      x_min      <= 12'hFFF;
      x_max      <= '0;
      y_min      <= 12'hFFF;
      y_max      <= '0;
`endif
    end else if (hit) begin
      sum_x <= sum_x + {20'd0, x_cur};
      sum_y <= sum_y + {20'd0, y_cnt};
      if (cnt != 20'hFFFFF)
        cnt <= cnt + 20'd1;
`ifdef COLOR_CENTROID_BBOX_EN
      if (x_cur < x_min) x_min <= x_cur;
      if (x_cur > x_max) x_max <= x_cur;
      if (y_cnt < y_min) y_min <= y_cnt;
      if (y_cnt > y_max) y_max <= y_cnt;
`endif
    end
  end

  // Freeze the finished frame's totals so the next frame can accumulate freely
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      snap_sum_x <= '0;
      snap_sum_y <= '0;
      snap_cnt   <= '0;
`ifdef COLOR_CENTROID_BBOX_EN
      snap_x_min <= '0;
      snap_x_max <= '0;
      snap_y_min <= '0;
      snap_y_max <= '0;
`endif
    end else if (start) begin
      snap_sum_x <= sum_x;
      snap_sum_y <= sum_y;
      snap_cnt   <= cnt;
`ifdef COLOR_CENTROID_BBOX_EN
      snap_x_min <= x_min;
      snap_x_max <= x_max;
      snap_y_min <= y_min;
      snap_y_max <= y_max;
`endif
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; a new frame boundary always restarts at CHECK
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      CHECK:   state_next = (snap_cnt < MIN_PIX) ? DONE : DIV_X;
      DIV_X:   if (iter == 5'd31) state_next = DIV_Y;
      DIV_Y:   if (iter == 5'd31) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (start)
      state_next = CHECK;
  end

  // One restoring-division step: shift in the next dividend bit and trial-subtract
  always_comb begin
    div_shift = {div_rem, div_quo[31]};
    div_ge    = div_shift >= {13'd0, snap_cnt};
    div_sub   = div_shift[31:0] - {12'd0, snap_cnt};
    publish   = (state == DONE) && !start;
    busy      = (state != IDLE);
  end

  // Divider datapath: x quotient first, then y, one quotient bit per cycle
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_rem <= '0;
      div_quo <= '0;
      iter    <= '0;
      quo_x   <= '0;
      found   <= 1'b0;
    end else if (!start) begin
      case (state)
        CHECK: begin
          found   <= !(snap_cnt < MIN_PIX);
          div_rem <= '0;
          div_quo <= snap_sum_x;
          iter    <= '0;
        end
        DIV_X, DIV_Y: begin
          div_rem <= div_ge ? div_sub : div_shift[31:0];
          div_quo <= {div_quo[30:0], div_ge};
          iter    <= iter + 5'd1;
          if ((state == DIV_X) && (iter == 5'd31)) begin
            quo_x   <= {div_quo[10:0], div_ge};
            div_rem <= '0;
            div_quo <= snap_sum_y;
          end
        end
        default: ;
      endcase
    end
  end

  // Publish results at DONE unless a new frame boundary just discarded them
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      obj_valid   <= 1'b0;
      obj_found   <= 1'b0;
      obj_x       <= '0;
      obj_y       <= '0;
      obj_pix_cnt <= '0;
`ifdef COLOR_CENTROID_BBOX_EN
      obj_x_min   <= '0;
      obj_x_max   <= '0;
      obj_y_min   <= '0;
      obj_y_max   <= '0;
`endif
    end else begin
      obj_valid <= publish;
      if (publish) begin
        obj_found   <= found;
        obj_x       <= found ? quo_x : 12'd0;
        obj_y       <= found ? div_quo[11:0] : 12'd0;
        obj_pix_cnt <= snap_cnt;
`ifdef COLOR_CENTROID_BBOX_EN
        obj_x_min   <= found ? snap_x_min : 12'd0;
        obj_x_max   <= found ? snap_x_max : 12'd0;
        obj_y_min   <= found ? snap_y_min : 12'd0;
        obj_y_max   <= found ? snap_y_max : 12'd0;
`endif
      end
    end
  end

endmodule
